inv_cipher_iter: RTL
====================

# inv_cipher_iter

Iterative AES inverse cipher (FIPS-197 §5.3) that decrypts one 128-bit block, applying one round per clock. It is the decryption-side counterpart of the combinational encryption datapath and consumes the same pre-expanded key schedule. It sits between the SPI receive buffer and the plaintext sink, with valid/ready handshakes on both sides.

## Interface
- Nr, 10: number of rounds (10/12/14).
- Nk, 4: key length in 32-bit words (4/6/8). Informational only; must be consistent with Nr.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ciphertext block and key schedule are presented.
- in_ready  output  1  core can accept a block (high only in IDLE).
- state  input  128  ciphertext, FIPS byte order: byte 0 = [127:120], column-major.
- w  input  128*(Nr+1)  expanded key schedule; round key j = w[j*128 +: 128].
- out_valid  output  1  Decrypted_Msg is valid.
- out_ready  input  1  sink accepts Decrypted_Msg.
- Decrypted_Msg  output  128  plaintext, same byte order as state.
- busy  output  1  high in ROUND and FINAL.

## Operation
- Round primitives (all combinational and internal): InvShiftRows (row r rotated right by r bytes), InvSubBytes (inverse S-box), InvMixColumns (GF(2^8) matrix {0e,0b,0d,09}, modulus 0x11b), and 128-bit XOR AddRoundKey.
- FSM states: IDLE, ROUND, FINAL, DONE. A 4-bit round counter rnd holds values Nr-1 down to 1.
- IDLE: in_ready=1. On an edge with in_valid=1, the core loads st <= state ^ w[Nr], sets rnd <= Nr-1, and goes to ROUND.
- ROUND: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ w[rnd]). If rnd==1 the FSM goes to FINAL; otherwise rnd decrements.
- FINAL: Decrypted_Msg <= InvSubBytes(InvShiftRows(st)) ^ w[0], out_valid <= 1, go to DONE.
- DONE: out_valid and Decrypted_Msg are held stable until out_ready=1. On that edge out_valid <= 0 and the FSM goes to IDLE.
- in_valid is ignored outside IDLE. No second block is accepted until the output has been consumed.
- Decrypted_Msg keeps its last value after the handshake completes. It changes only in FINAL or on reset.

## Timing
- Reset values: out_valid=0, Decrypted_Msg=128'h0, busy=0, FSM=IDLE, so in_ready=1. rnd=0, st=0.
- Latency: the accept edge is k. The FSM is in ROUND for edges k+1 .. k+Nr-1 and in FINAL at edge k+Nr. out_valid is high from just after edge k+Nr.
- With out_ready held at 1, the block occupies the core for Nr+1 cycles from accept to handshake. in_ready rises one cycle after the output handshake. Peak throughput is one block per Nr+2 cycles.
- out_ready asserted before out_valid has no effect.
- Reset asserted mid-operation (ROUND, FINAL or DONE): outputs clear immediately, without waiting for a clock edge. The block in flight is discarded and no out_valid is produced.
- Without AES_DEC_KEY_LATCH_EN, w must stay stable from the accept edge through edge k+Nr. state is sampled only at the accept edge.

## Configuration
- AES_DEC_KEY_LATCH_EN defined: at the accept edge, w is copied into an internal 128*(Nr+1)-bit register. All rounds use the copy, so w may change freely after acceptance. The register resets to 0.
- AES_DEC_KEY_LATCH_EN undefined: there is no key register and rounds index w directly. The stability requirement under Timing applies. Cycle timing is identical in both builds.

## Test plan
- AES-128, Nr=10: state=69c4e0d86a7b0430d8cdb78070b4c55a with the schedule expanded from key 000102030405060708090a0b0c0d0e0f -> Decrypted_Msg=00112233445566778899aabbccddeeff, with out_valid rising exactly 10 cycles after the accept edge.
- AES-128, Nr=10: state=3925841d02dc09fbdc118597196a0b32 with key 2b7e151628aed2a6abf7158809cf4f3c -> Decrypted_Msg=3243f6a8885a308d313198a2e0370734.
- AES-256 build (Nr=14, Nk=8): state=8ea2b7ca516745bfeafc49904b496089 with key 000102…1e1f -> Decrypted_Msg=00112233445566778899aabbccddeeff, with latency 14 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with a new block during that time -> out_valid and data stay stable, in_ready=0, and the new block is not accepted. Then release out_ready -> out_valid drops, and in_ready goes high on the next cycle.
- Reset at accept+4 -> out_valid stays 0, Decrypted_Msg=0, and in_ready=1 immediately. A following block decrypts correctly.
- AES_DEC_KEY_LATCH_EN build: overwrite w with all-ones one cycle after accept -> the result still matches the FIPS vector.

Source files
------------

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: decrypts one 128-bit block, one round per clock, from a pre-expanded key schedule.
// Define AES_DEC_KEY_LATCH_EN to capture the key schedule at accept so w may change while the block is in flight.
module inv_cipher_iter #(
   parameter int Nr = 10,
   parameter int Nk = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [127:0]          state,
   input  logic [128*(Nr+1)-1:0] w,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          Decrypted_Msg,
   output logic                  busy
);

   localparam int KS_W = 128*(Nr+1);

   // Inverse S-box, entry 0 in the most significant byte
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

   fsm_t            cur_st;
   fsm_t            nxt_st;
   logic [127:0]    st;
   logic [3:0]      rnd;
   logic [KS_W-1:0] ks;
   logic [127:0]    rk;
   logic [127:0]    sub_out;
   logic [127:0]    round_out;
   logic [127:0]    final_out;

   generate
      if (Nk + 6 != Nr) begin : g_bad_cfg
         $error("inv_cipher_iter: Nk is inconsistent with Nr");
      end
   endgenerate

   // Combined InvShiftRows + InvSubBytes: output byte (row b, col c) comes from input col (c - b) mod 4
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] a);
      logic [127:0] res;
      logic [7:0]   src;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int b = 0; b < 4; b++) begin
            src = a[127-8*(4*((c-b+4)%4)+b) -: 8];
            res[127-8*(4*c+b) -: 8] = INV_SBOX[2047-8*int'(src) -: 8];
         end
      end
      return res;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xt(a[i]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] a);
      logic [127:0] res;
      for (int c = 0; c < 4; c++) begin
         res[127-32*c -: 32] = inv_mix_col(a[127-32*c -: 32]);
      end
      return res;
   endfunction

`ifdef AES_DEC_KEY_LATCH_EN
   logic [KS_W-1:0] key_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q <= '0;
      end else if (cur_st == IDLE && in_valid) begin
         key_q <= w;
      end
   end

   assign ks = key_q;
`else
   assign ks = w;
`endif

   always_comb begin
      rk        = ks[128*int'(rnd) +: 128];
      sub_out   = inv_shift_sub(st);
      round_out = inv_mix(sub_out ^ rk);
      final_out = sub_out ^ ks[127:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_st <= IDLE;
      end else begin
         cur_st <= nxt_st;
      end
   end

   always_comb begin
      nxt_st    = cur_st;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      unique case (cur_st)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               nxt_st = ROUND;
            end
         end
         ROUND: begin
            busy = 1'b1;
            if (rnd == 4'd1) begin
               nxt_st = FINAL;
            end
         end
         FINAL: begin
            busy   = 1'b1;
            nxt_st = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               nxt_st = IDLE;
            end
         end
         default: nxt_st = IDLE;
      endcase
   end

   // The initial AddRoundKey uses w directly because a latched copy is not available until after this edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st            <= '0;
         rnd           <= '0;
         Decrypted_Msg <= '0;
      end else begin
         case (cur_st)
            IDLE: begin
               if (in_valid) begin
                  st  <= state ^ w[KS_W-1 -: 128];
                  rnd <= 4'(Nr - 1);
               end
            end
            ROUND: begin
               st <= round_out;
               if (rnd != 4'd1) begin
                  rnd <= rnd - 4'd1;
               end
            end
            FINAL: begin
               Decrypted_Msg <= final_out;
            end
            default: ;
         endcase
      end
   end

endmodule
